mul_arbiter: RTL and testbench

Two-port controller that shares one iterative 32x32 unsigned multiplier between two requesters (e.g. the EX-stage MUL unit of two pipelines, or a core and a DMA/accelerator port). Arbitrates round-robin, converts signed operations to unsigned magnitudes, sequences the multiplier's `in_valid`/`out_valid` handshake, then sign-corrects and selects the 32-bit result half. Sits between requesters and the multiplier instance.

---
 rtl/mul_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_mul_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// mul_arbiter
//
// Shares one iterative 32x32 unsigned multiplier between two requesters.
// Arbitration is round-robin. Signed operands are turned into unsigned
// magnitudes before issue, and the 64-bit product is sign-corrected on the
// way back. The final step selects the low or high 32-bit half.
//
// Ports
//   clk, rst            clock (rising edge) and async active-high reset
//   req[1:0]            per-port request; bit i = port i
//   a0/b0/op0           port 0 operands (a = multiplier, b = multiplicand)
//                       and op: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   a1/b1/op1           port 1 equivalents
//   ack[1:0]            combinational one-cycle grant pulse. Operands are
//                       captured on the clock edge that ends the pulse.
//   resp_valid[1:0]     registered one-cycle result pulse to the granted port
//   resp_data[31:0]     result; meaningful only while resp_valid is set
//   busy                high in every state except IDLE
//   mul_in_valid        one-cycle start pulse to the multiplier
//   mul_mplier/mcand    unsigned operand magnitudes, held through WAIT
//   mul_product[63:0]   multiplier result
//   mul_out_valid       multiplier result strobe; only honoured in WAIT
//
// Handshake: a requester holds req and its operands until it sees its ack
// bit. The operands are taken on that clock edge. If req is still high after
// ack, it counts as a fresh request. Exactly one resp_valid pulse follows
// each ack, unless reset intervenes. The multiplier has no in_ready. It must
// share this block's reset, and it sees at most one operation in flight.
//
// Optional feature: define MUL_RESULT_CACHE_EN to keep the last magnitude
// pair and its unsigned product. A grant whose magnitudes match that pair is
// answered straight from the cache and does not use the multiplier.

module mul_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [1:0]  op0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic [1:0]  op1,
    output logic [1:0]  ack,
    output logic [1:0]  resp_valid,
    output logic [31:0] resp_data,
    output logic        busy,
    output logic        mul_in_valid,
    output logic [31:0] mul_mplier,
    output logic [31:0] mul_mcand,
    input  logic [63:0] mul_product,
    input  logic        mul_out_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        last_grant;
    logic        grant_id;
    logic [1:0]  op_q;
    logic        neg_q;

    logic        grant_sel;
    logic        grant_fire;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [1:0]  sel_op;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        sel_neg;
    logic        cache_hit;

`ifdef MUL_RESULT_CACHE_EN
    logic        cache_valid;
    logic [31:0] cache_a;
    logic [31:0] cache_b;
    logic [63:0] cache_prod;
`endif

    // Sign-correct the unsigned product, then pick the half the op asks for.
    function automatic logic [31:0] shape_result(input logic [63:0] prod,
                                                 input logic        neg,
                                                 input logic [1:0]  op);
        logic [63:0] p;
        p = neg ? (~prod + 64'd1) : prod;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Round-robin: when both ports request, the port not granted last wins.
    always_comb begin
        grant_sel = 1'b0;
        case (req)
            2'b01:   grant_sel = 1'b0;
            2'b10:   grant_sel = 1'b1;
            2'b11:   grant_sel = ~last_grant;
            default: grant_sel = 1'b0;
        endcase
    end

    assign sel_a  = grant_sel ? a1  : a0;
    assign sel_b  = grant_sel ? b1  : b0;
    assign sel_op = grant_sel ? op1 : op0;

    // a is signed for MULH and MULHSU; b is signed only for MULH.
    // Negating 0x80000000 gives 0x80000000, which is the correct magnitude.
    assign sign_a  = sel_a[31] & ((sel_op == 2'b01) | (sel_op == 2'b10));
    assign sign_b  = sel_b[31] & (sel_op == 2'b01);
    assign mag_a   = sign_a ? (~sel_a + 32'd1) : sel_a;
    assign mag_b   = sign_b ? (~sel_b + 32'd1) : sel_b;
    assign sel_neg = sign_a ^ sign_b;

    assign grant_fire = (state == IDLE) && (req != 2'b00) && !rst;
    assign ack        = grant_fire ? (grant_sel ? 2'b10 : 2'b01) : 2'b00;
    assign busy       = (state != IDLE);

`ifdef MUL_RESULT_CACHE_EN
    // The match uses magnitudes only. The op and the sign come from the new
    // request, so a signed op can hit on an entry left by an unsigned one.
    assign cache_hit = cache_valid && (mag_a == cache_a) && (mag_b == cache_b);
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_fire) state_next = cache_hit ? DONE : ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (mul_out_valid) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The result is computed on the edge that enters DONE. That keeps
    // resp_data and resp_valid registered while they are visible in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant   <= 1'b1;
            grant_id     <= 1'b0;
            op_q         <= 2'b00;
            neg_q        <= 1'b0;
            resp_valid   <= 2'b00;
            resp_data    <= 32'd0;
            mul_in_valid <= 1'b0;
            mul_mplier   <= 32'd0;
            mul_mcand    <= 32'd0;
`ifdef MUL_RESULT_CACHE_EN
            cache_valid  <= 1'b0;
            cache_a      <= 32'd0;
            cache_b      <= 32'd0;
            cache_prod   <= 64'd0;
`endif
        end else begin
            mul_in_valid <= 1'b0;
            resp_valid   <= 2'b00;
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        last_grant <= grant_sel;
                        grant_id   <= grant_sel;
                        op_q       <= sel_op;
                        neg_q      <= sel_neg;
`ifdef MUL_RESULT_CACHE_EN
                        if (cache_hit) begin
                            resp_valid <= grant_sel ? 2'b10 : 2'b01;
                            resp_data  <= shape_result(cache_prod, sel_neg, sel_op);
                        end else begin
                            mul_in_valid <= 1'b1;
                            mul_mplier   <= mag_a;
                            mul_mcand    <= mag_b;
                        end
`else
                        mul_in_valid <= 1'b1;
                        mul_mplier   <= mag_a;
                        mul_mcand    <= mag_b;
`endif
                    end
                end
                WAIT: begin
                    if (mul_out_valid) begin
                        resp_valid <= grant_id ? 2'b10 : 2'b01;
                        resp_data  <= shape_result(mul_product, neg_q, op_q);
`ifdef MUL_RESULT_CACHE_EN
                        cache_valid <= 1'b1;
                        cache_a     <= mul_mplier;
                        cache_b     <= mul_mcand;
                        cache_prod  <= mul_product;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Testbench for mul_arbiter. It includes a latency-4 multiplier model, and
// the expected values in the directed vectors are hand-computed.
// The timing expectations change when MUL_RESULT_CACHE_EN is defined.

module tb_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  op0, op1;
    logic [1:0]  ack;
    logic [1:0]  resp_valid;
    logic [31:0] resp_data;
    logic        busy;
    logic        mul_in_valid;
    logic [31:0] mul_mplier;
    logic [31:0] mul_mcand;
    logic [63:0] mul_product;
    logic        mul_out_valid;

`ifdef MUL_RESULT_CACHE_EN
    localparam int HIT_LAT = 1;
    localparam int HIT_IV  = 0;
`else
    localparam int HIT_LAT = 6;
    localparam int HIT_IV  = 1;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Information about the most recent wait_resp call.
    int          last_iv_at;
    logic [31:0] last_mp;
    logic [31:0] last_mc;

    mul_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .a0            (a0),
        .b0            (b0),
        .op0           (op0),
        .a1            (a1),
        .b1            (b1),
        .op1           (op1),
        .ack           (ack),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .busy          (busy),
        .mul_in_valid  (mul_in_valid),
        .mul_mplier    (mul_mplier),
        .mul_mcand     (mul_mcand),
        .mul_product   (mul_product),
        .mul_out_valid (mul_out_valid)
    );

    // ---- clock / reset ----
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---- multiplier model, L = 4: out_valid four cycles after in_valid ----
    logic [63:0] m_prod;
    logic        m_ov;
    int          m_cnt;
    logic        spur;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 0;
            m_ov   <= 1'b0;
            m_prod <= 64'd0;
        end else begin
            m_ov <= (m_cnt == 1);
            if (m_cnt != 0) m_cnt <= m_cnt - 1;
            if (mul_in_valid) begin
                m_cnt  <= 3;
                m_prod <= {32'd0, mul_mplier} * {32'd0, mul_mcand};
            end
        end
    end

    assign mul_product   = m_prod;
    assign mul_out_valid = m_ov | spur;

    // ---- checking ----
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---- driver tasks ----
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Call this just after driving req on a negedge.
    task automatic wait_ack(output logic [1:0] av, output int at);
        av = 2'b00;
        at = -1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (ack != 2'b00) begin
                av = ack;
                at = cyc;
                return;
            end
            @(negedge clk);
        end
        check("ack_timeout", 1, 0);
    endtask

    task automatic wait_resp(output logic [1:0] port, output logic [31:0] data,
                             output int at, output int iv_n);
        port = 2'b00;
        data = 32'd0;
        at = -1;
        iv_n = 0;
        last_iv_at = -1;
        last_mp = 32'd0;
        last_mc = 32'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (mul_in_valid) begin
                if (iv_n == 0) begin
                    last_iv_at = cyc;
                    last_mp = mul_mplier;
                    last_mc = mul_mcand;
                end
                iv_n++;
            end
            if (resp_valid != 2'b00) begin
                port = resp_valid;
                data = resp_data;
                at = cyc;
                return;
            end
        end
        check("resp_timeout", 1, 0);
    endtask

    int op_t0;

    task automatic run_op(input logic port, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [31:0] exp,
                          input int exp_lat, input int exp_iv, input string tag);
        logic [1:0]  av;
        logic [1:0]  exp_port;
        logic [1:0]  rp;
        logic [31:0] rd;
        int          t0;
        int          tr;
        int          ivn;
        exp_port = port ? 2'b10 : 2'b01;
        @(negedge clk);
        if (port) begin
            a1 = a; b1 = b; op1 = op;
        end else begin
            a0 = a; b0 = b; op0 = op;
        end
        req = exp_port;
        wait_ack(av, t0);
        op_t0 = t0;
        check({tag, "_ack"}, av, exp_port);
        @(posedge clk);
        #1;
        req = 2'b00;
        wait_resp(rp, rd, tr, ivn);
        check({tag, "_port"}, rp, exp_port);
        check({tag, "_data"}, rd, exp);
        check({tag, "_lat"}, tr - t0, exp_lat);
        check({tag, "_ivcnt"}, ivn, exp_iv);
    endtask

    // ---- stimulus ----
    initial begin
        logic [1:0]  av;
        logic [1:0]  exp_port;
        logic [1:0]  rp;
        logic [31:0] rd;
        int          t;
        int          tr;
        int          ivn;
        int          prev_ack;
        int          last_r;
        int          anom;

        rst = 1'b1;
        spur = 1'b0;
        req = 2'b01;
        a0 = 32'd1; b0 = 32'd1; op0 = 2'b00;
        a1 = 32'd0; b1 = 32'd0; op1 = 2'b00;
        #2;
        // Reset state: ack must stay low even though req is high.
        check("rst_ack", ack, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_resp_valid", resp_valid, 2'b00);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_in_valid", mul_in_valid, 1'b0);
        check("rst_mplier", mul_mplier, 32'd0);
        check("rst_mcand", mul_mcand, 32'd0);
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        rst = 1'b0;

        // Basic MUL on port 0, including issue timing and operands.
        run_op(1'b0, 32'd7, 32'd6, 2'b00, 32'd42, 6, 1, "mul7x6");
        check("mul7x6_ivcyc", last_iv_at - op_t0, 1);
        check("mul7x6_mplier", last_mp, 32'd7);
        check("mul7x6_mcand", last_mc, 32'd6);

        // Signed ops on port 1.
        run_op(1'b1, 32'hFFFF_FFFE, 32'd3, 2'b00, 32'hFFFF_FFFA, 6, 1, "mul_neg");
        run_op(1'b1, 32'hFFFF_FFFE, 32'd3, 2'b01, 32'hFFFF_FFFF, 6, 1, "mulh_neg");
        run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFE, 6, 1, "mulhu");
        run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFF, 6, 1, "mulhsu");
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000, 6, 1, "mulh_min");
        check("mulh_min_mplier", last_mp, 32'h8000_0000);

        // Contention: req=11 held from reset gives the order 0,1,0,1.
        do_reset();
        @(negedge clk);
        a0 = 32'd3;  b0 = 32'd4;  op0 = 2'b00;
        a1 = 32'd10; b1 = 32'd11; op1 = 2'b00;
        req = 2'b11;
        prev_ack = -1;
        last_r = -1;
        for (int n = 0; n < 4; n++) begin
            exp_port = (n % 2 == 1) ? 2'b10 : 2'b01;
            wait_ack(av, t);
            check("rr_ack", av, exp_port);
            if (n > 0) begin
                check("rr_gap_resp", (t - last_r) >= 1, 1'b1);
                check("rr_gap_ack", t - prev_ack, 7);
            end
            prev_ack = t;
            if (n == 3) begin
                @(posedge clk);
                #1;
                req = 2'b00;
            end
            wait_resp(rp, rd, tr, ivn);
            check("rr_resp_port", rp, exp_port);
            check("rr_resp_data", rd, (n % 2 == 1) ? 32'd110 : 32'd12);
            last_r = tr;
        end

        // Reset during WAIT drops the op.
        @(negedge clk);
        a0 = 32'd100; b0 = 32'd200; op0 = 2'b00;
        req = 2'b01;
        wait_ack(av, t);
        check("rw_ack", av, 2'b01);
        @(posedge clk);
        #1;
        req = 2'b00;
        repeat (3) @(negedge clk);
        check("rw_busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rw_busy", busy, 1'b0);
        check("rw_ack0", ack, 2'b00);
        check("rw_resp_valid", resp_valid, 2'b00);
        check("rw_resp_data", resp_data, 32'd0);
        check("rw_in_valid", mul_in_valid, 1'b0);
        check("rw_mplier", mul_mplier, 32'd0);
        check("rw_mcand", mul_mcand, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        anom = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (resp_valid != 2'b00 || busy) anom++;
        end
        check("rw_no_resp", anom, 0);
        run_op(1'b0, 32'd100, 32'd200, 2'b00, 32'd20000, 6, 1, "rw_after");

        // A spurious out_valid in IDLE must be ignored.
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        anom = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (busy || resp_valid != 2'b00) anom++;
            @(negedge clk);
        end
        check("spur_quiet", anom, 0);

        // Result cache (or the plain path when the macro is off).
        run_op(1'b0, 32'd5, 32'd9, 2'b00, 32'd45, 6, 1, "c_first");
        run_op(1'b0, 32'd5, 32'd9, 2'b00, 32'd45, HIT_LAT, HIT_IV, "c_repeat");
        run_op(1'b1, 32'hFFFF_FFFB, 32'd9, 2'b01, 32'hFFFF_FFFF, HIT_LAT, HIT_IV, "c_signed");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
